// File: rtl/cpu_isa_pkg.sv
// Shared ISA definitions for the instruction encoder and (later) the decoder:
// op enum, opcode/funct constants, field positions and a word-assembly helper.
package cpu_isa_pkg;

  typedef enum logic [3:0] {
    OP_ADD = 4'd0,
    OP_SUB = 4'd1,
    OP_AND = 4'd2,
    OP_OR  = 4'd3,
    OP_XOR = 4'd4,
    OP_SW  = 4'd5,
    OP_LW  = 4'd6,
    OP_J   = 4'd7,
    OP_MOV = 4'd8,
    OP_SLL = 4'd9,
    OP_CMP = 4'd10,
    OP_BBT = 4'd11
  } op_e;

  localparam logic [5:0] OPC_RTYPE = 6'b000000;
  localparam logic [5:0] OPC_SW    = 6'b101011;
  localparam logic [5:0] OPC_LW    = 6'b100011;
  localparam logic [5:0] OPC_J     = 6'b000010;
  localparam logic [5:0] OPC_CMP   = 6'b111110;
  localparam logic [5:0] OPC_BBT   = 6'b111111;

  localparam logic [5:0] FN_ADD = 6'b100000;
  localparam logic [5:0] FN_SUB = 6'b100010;
  localparam logic [5:0] FN_AND = 6'b100100;
  localparam logic [5:0] FN_OR  = 6'b100101;
  localparam logic [5:0] FN_XOR = 6'b100110;
  localparam logic [5:0] FN_SLL = 6'b000000;

  localparam logic [10:0] LOW_MOV = 11'b00000001010;
  localparam logic [10:0] LOW_CMP = 11'b00000000000;

  localparam int OPC_LSB   = 26;
  localparam int RS_LSB    = 21;
  localparam int RT_LSB    = 16;
  localparam int RD_LSB    = 11;
  localparam int SHAMT_LSB = 6;

  // opcode | rs | rt | low16, where low16 is either imm16 or {rd, low11}
  function automatic logic [31:0] enc_i(logic [5:0] opc, logic [4:0] rs,
                                        logic [4:0] rt, logic [15:0] low);
    logic [31:0] w;
    w = '0;
    w[OPC_LSB +: 6] = opc;
    w[RS_LSB +: 5]  = rs;
    w[RT_LSB +: 5]  = rt;
    w[15:0]         = low;
    return w;
  endfunction

endpackage

// File: rtl/cpu_inst_pack.sv
// Combinational encoder: symbolic op plus register/immediate fields to the
// 32-bit instruction word; valid is low for the unassigned op codes 12-15.
module cpu_inst_pack
  import cpu_isa_pkg::*;
(
  input  logic [3:0]  op,
  input  logic [4:0]  rs,
  input  logic [4:0]  rt,
  input  logic [4:0]  rd,
  input  logic [25:0] imm,
  output logic [31:0] word,
  output logic        valid
);

  logic [4:0] shamt;
  assign shamt = imm[4:0];

  always_comb begin
    word  = '0;
    valid = 1'b1;
    case (op_e'(op))
      OP_ADD: word = enc_i(OPC_RTYPE, rs, rt, {rd, 5'b0, FN_ADD});
      OP_SUB: word = enc_i(OPC_RTYPE, rs, rt, {rd, 5'b0, FN_SUB});
      OP_AND: word = enc_i(OPC_RTYPE, rs, rt, {rd, 5'b0, FN_AND});
      OP_OR:  word = enc_i(OPC_RTYPE, rs, rt, {rd, 5'b0, FN_OR});
      OP_XOR: word = enc_i(OPC_RTYPE, rs, rt, {rd, 5'b0, FN_XOR});
      OP_SW:  word = enc_i(OPC_SW, rs, rt, imm[15:0]);
      OP_LW:  word = enc_i(OPC_LW, rs, rt, imm[15:0]);
      OP_J:   word = {OPC_J, imm};
      OP_MOV: word = enc_i(OPC_RTYPE, rs, rt, {rd, LOW_MOV});
      // the decoder expects rs == 0 for shifts
      OP_SLL: word = enc_i(OPC_RTYPE, 5'd0, rt, {rd, shamt, FN_SLL});
      OP_CMP: word = enc_i(OPC_CMP, rs, rt, {rd, LOW_CMP});
      OP_BBT: word = enc_i(OPC_BBT, rs, rt, imm[15:0]);
      default: valid = 1'b0;
    endcase
  end

endmodule

// File: rtl/cpu_inst_encoder.sv
// Instruction-memory loader: takes one symbolic instruction per handshake,
// encodes it and writes it to consecutive addresses from a programmable base.
//
// state   | meaning
// IDLE    | no session since reset; waiting for start
// LOAD    | session open; requests accepted while not full
// DONE    | session closed by last/DEPTH; outputs hold until next start
module cpu_inst_encoder
  import cpu_isa_pkg::*;
#(
  parameter int ADDR_W = 8,
  parameter int DEPTH  = 256
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [3:0]        req_op,
  input  logic [4:0]        req_rs,
  input  logic [4:0]        req_rt,
  input  logic [4:0]        req_rd,
  input  logic [25:0]       req_imm,
  input  logic              req_last,
  output logic              im_wen,
  output logic [ADDR_W-1:0] im_addr,
  output logic [31:0]       im_wdata,
  output logic              busy,
  output logic              done,
  output logic              full,
  output logic              err,
  output logic [ADDR_W:0]   count
);

  typedef enum logic [1:0] {ST_IDLE, ST_LOAD, ST_DONE} state_e;

  localparam logic [ADDR_W:0]   DEPTH_CNT = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W+1:0] DEPTH_EXT = (ADDR_W+2)'(DEPTH);

  state_e            state;
  logic [ADDR_W-1:0] ptr;
  logic [31:0]       pack_word;
  logic              pack_ok;
  logic              accept;
  logic              reach_depth;
  logic [ADDR_W+1:0] words_after;

  cpu_inst_pack u_pack (
    .op    (req_op),
    .rs    (req_rs),
    .rt    (req_rt),
    .rd    (req_rd),
    .imm   (req_imm),
    .word  (pack_word),
    .valid (pack_ok)
  );

  assign full      = (count == DEPTH_CNT);
  assign req_ready = (state == ST_LOAD) && !full;
  assign accept    = req_valid && req_ready;
  assign busy      = (state == ST_LOAD) || im_wen;
  assign done      = (state == ST_DONE);

  // count lags the accept by one cycle, so a still-pending write counts too
  assign words_after = {1'b0, count} + (ADDR_W+2)'(im_wen) + (ADDR_W+2)'(1);
  assign reach_depth = pack_ok && (words_after == DEPTH_EXT);

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state    <= ST_IDLE;
      ptr      <= '0;
      count    <= '0;
      err      <= 1'b0;
      im_wen   <= 1'b0;
      im_addr  <= '0;
      im_wdata <= '0;
    end else begin
      im_wen <= 1'b0;
      if (im_wen) count <= count + (ADDR_W+1)'(1);
      unique case (state)
        ST_IDLE, ST_DONE: begin
          if (start) begin
            state <= ST_LOAD;
            ptr   <= base_addr;
            count <= '0;
            err   <= 1'b0;
          end
        end
        ST_LOAD: begin
          if (accept) begin
            if (pack_ok) begin
              im_wen   <= 1'b1;
              im_addr  <= ptr;
              im_wdata <= pack_word;
              ptr      <= ptr + ADDR_W'(1);
            end else begin
              err <= 1'b1;
            end
            if (req_last || reach_depth) state <= ST_DONE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_cpu_inst_encoder.sv
// Self-checking bench for cpu_inst_encoder: directed scenarios with known
// encodings plus randomized sessions against a session-level reference model.
module tb_cpu_inst_encoder;

  localparam int ADDR_W = 8;
  localparam int DEPTH  = 4;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic        start = 1'b0;
  logic [7:0]  base_addr = '0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [3:0]  req_op = '0;
  logic [4:0]  req_rs = '0, req_rt = '0, req_rd = '0;
  logic [25:0] req_imm = '0;
  logic        req_last = 1'b0;
  logic        im_wen;
  logic [7:0]  im_addr;
  logic [31:0] im_wdata;
  logic        busy, done, full, err;
  logic [8:0]  count;

  int errors = 0;
  int checks = 0;

  cpu_inst_encoder #(.ADDR_W(ADDR_W), .DEPTH(DEPTH)) dut (
    .clk(clk), .resetn(resetn), .start(start), .base_addr(base_addr),
    .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
    .req_rs(req_rs), .req_rt(req_rt), .req_rd(req_rd), .req_imm(req_imm),
    .req_last(req_last), .im_wen(im_wen), .im_addr(im_addr),
    .im_wdata(im_wdata), .busy(busy), .done(done), .full(full), .err(err),
    .count(count)
  );

  always #5 clk = ~clk;

  // request table for one session
  logic [3:0]  r_op[8];
  logic [4:0]  r_rs[8], r_rt[8], r_rd[8];
  logic [25:0] r_imm[8];
  logic        r_last[8];
  int          nreq;

  // observations from the last session
  int          acc_cyc[$];
  logic [7:0]  w_addr[$];
  logic [31:0] w_data[$];
  int          w_cyc[$];
  int          w_cnt[$];
  logic        rdy_after;

  // reference model results
  logic [7:0]  e_addr[$];
  logic [31:0] e_data[$];
  int          e_widx[$];
  int          e_acc, e_count;
  logic        e_err, e_done;

  function automatic logic [31:0] ref_enc(input int unsigned op, rs, rt, rd, imm);
    int unsigned r3;
    r3 = (rs << 21) | (rt << 16) | (rd << 11);
    case (op)
      0:  return 32'(r3 | 32);
      1:  return 32'(r3 | 34);
      2:  return 32'(r3 | 36);
      3:  return 32'(r3 | 37);
      4:  return 32'(r3 | 38);
      5:  return 32'((43 << 26) | (rs << 21) | (rt << 16) | (imm & 16'hFFFF));
      6:  return 32'((35 << 26) | (rs << 21) | (rt << 16) | (imm & 16'hFFFF));
      7:  return 32'((2 << 26) | (imm & 26'h3FFFFFF));
      8:  return 32'(r3 | 10);
      9:  return 32'((rt << 16) | (rd << 11) | ((imm & 31) << 6));
      10: return 32'((62 << 26) | r3);
      11: return 32'((63 << 26) | (rs << 21) | (rt << 16) | (imm & 16'hFFFF));
      default: return 32'd0;
    endcase
  endfunction

  // Session semantics: every offered request is consumed in order until one
  // carries last or the DEPTH-th valid word is taken; invalid ops write nothing.
  task automatic model_session(input logic [7:0] b);
    int k;
    e_addr.delete(); e_data.delete(); e_widx.delete();
    k = 0; e_acc = 0; e_err = 1'b0; e_done = 1'b0;
    for (int i = 0; i < nreq; i++) begin
      e_acc++;
      if (r_op[i] < 12) begin
        e_addr.push_back(8'((b + k) % 256));
        e_data.push_back(ref_enc(r_op[i], r_rs[i], r_rt[i], r_rd[i], r_imm[i]));
        e_widx.push_back(i);
        k++;
      end else begin
        e_err = 1'b1;
      end
      if (r_last[i] || k == DEPTH) begin
        e_done = 1'b1;
        break;
      end
    end
    e_count = k;
  endtask

  task automatic set_req(input int i, input int op, rs, rt, rd, imm, input logic last);
    r_op[i] = 4'(op); r_rs[i] = 5'(rs); r_rt[i] = 5'(rt); r_rd[i] = 5'(rd);
    r_imm[i] = 26'(imm); r_last[i] = last;
  endtask

  task automatic capture(input int cyc);
    if (im_wen) begin
      w_addr.push_back(im_addr);
      w_data.push_back(im_wdata);
      w_cyc.push_back(cyc);
      w_cnt.push_back(int'(count));
    end
  endtask

  task automatic run_session(input logic [7:0] b, input bit gaps);
    int  idx, cyc;
    bit  take;
    acc_cyc.delete(); w_addr.delete(); w_data.delete(); w_cyc.delete(); w_cnt.delete();
    rdy_after = 1'bx;
    @(negedge clk); start = 1'b1; base_addr = b;
    @(negedge clk); start = 1'b0; base_addr = 8'($urandom);
    idx = 0; cyc = 0;
    while (idx < nreq && done !== 1'b1 && cyc < 100) begin
      if (gaps && $urandom_range(0, 2) == 0) begin
        req_valid = 1'b0;
      end else begin
        req_valid = 1'b1;
        req_op = r_op[idx]; req_rs = r_rs[idx]; req_rt = r_rt[idx];
        req_rd = r_rd[idx]; req_imm = r_imm[idx]; req_last = r_last[idx];
      end
      take = req_valid && req_ready;
      @(posedge clk);
      if (take) begin
        acc_cyc.push_back(cyc);
        idx++;
      end
      @(negedge clk);
      cyc++;
      if (take) rdy_after = req_ready;
      capture(cyc);
    end
    checks++;
    if (cyc >= 100) begin
      errors++;
      $display("FAIL session_timeout: session did not close, cycles=%0d required<100", cyc);
    end
    // keep valid asserted: a closed session must not take anything more
    repeat (2) begin
      @(negedge clk); cyc++;
      capture(cyc);
    end
    req_valid = 1'b0;
  endtask

  task automatic test_reset;
    #12;
    checks++;
    if ({req_ready, im_wen, busy, done, full, err} !== 6'b0 || count !== 9'd0 ||
        im_addr !== 8'd0 || im_wdata !== 32'd0) begin
      errors++;
      $display("FAIL reset_values: got ready=%b wen=%b busy=%b done=%b full=%b err=%b count=%0d addr=%h data=%h required all 0",
               req_ready, im_wen, busy, done, full, err, count, im_addr, im_wdata);
    end
    @(negedge clk); resetn = 1'b1;
    @(negedge clk);
    checks++;
    if (req_ready !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL idle_ready: got ready=%b busy=%b required 0 0", req_ready, busy);
    end
  endtask

  task automatic test_single_add;
    nreq = 1;
    set_req(0, 0, 1, 2, 3, 0, 1'b1);
    run_session(8'h10, 1'b0);
    checks++;
    if (w_addr.size() !== 1 || w_addr[0] !== 8'h10 || w_data[0] !== 32'h00221820) begin
      errors++;
      $display("FAIL single_add: got n=%0d addr=%h data=%h required n=1 addr=10 data=00221820",
               w_addr.size(), w_addr[0], w_data[0]);
    end
    checks++;
    if (w_cyc[0] !== acc_cyc[0] + 1 || w_cnt[0] !== 0) begin
      errors++;
      $display("FAIL single_latency: got write_cycle=%0d count_at_write=%0d required %0d 0",
               w_cyc[0], w_cnt[0], acc_cyc[0] + 1);
    end
    checks++;
    if (count !== 9'd1 || done !== 1'b1 || busy !== 1'b0 || err !== 1'b0 || rdy_after !== 1'b0) begin
      errors++;
      $display("FAIL single_status: got count=%0d done=%b busy=%b err=%b ready=%b required 1 1 0 0 0",
               count, done, busy, err, rdy_after);
    end
  endtask

  task automatic test_back_to_back;
    nreq = 2;
    set_req(0, 6, 4, 5, 17, 16'h0010, 1'b0);
    set_req(1, 9, 9, 6, 7, 3, 1'b1);
    run_session(8'h10, 1'b0);
    checks++;
    if (w_addr.size() !== 2 || w_addr[0] !== 8'h10 || w_data[0] !== 32'h8C850010 ||
        w_addr[1] !== 8'h11 || w_data[1] !== 32'h000638C0) begin
      errors++;
      $display("FAIL lw_sll: got n=%0d %h@%h %h@%h required 8c850010@10 000638c0@11",
               w_addr.size(), w_data[0], w_addr[0], w_data[1], w_addr[1]);
    end
    checks++;
    if (acc_cyc[1] !== acc_cyc[0] + 1 || w_cyc[1] !== w_cyc[0] + 1) begin
      errors++;
      $display("FAIL lw_sll_throughput: got accepts %0d,%0d writes %0d,%0d required consecutive",
               acc_cyc[0], acc_cyc[1], w_cyc[0], w_cyc[1]);
    end
  endtask

  task automatic test_j_cmp_bbt;
    nreq = 3;
    set_req(0, 7, 21, 22, 23, 26'h40, 1'b0);
    set_req(1, 10, 1, 2, 3, 26'h3FF_FFFF, 1'b0);
    set_req(2, 11, 0, 0, 31, 26'h3FF_1234, 1'b1);
    run_session(8'h40, 1'b0);
    checks++;
    if (w_data.size() !== 3 || w_data[0] !== 32'h08000040 || w_data[1] !== 32'hF8221800 ||
        w_data[2] !== 32'hFC001234) begin
      errors++;
      $display("FAIL j_cmp_bbt: got n=%0d %h %h %h required 08000040 f8221800 fc001234",
               w_data.size(), w_data[0], w_data[1], w_data[2]);
    end
    checks++;
    if (w_addr[2] !== 8'h42 || count !== 9'd3) begin
      errors++;
      $display("FAIL j_cmp_bbt_addr: got last_addr=%h count=%0d required 42 3", w_addr[2], count);
    end
  endtask

  task automatic test_invalid;
    nreq = 3;
    set_req(0, 0, 1, 2, 3, 0, 1'b0);
    set_req(1, 13, 4, 5, 6, 7, 1'b0);
    set_req(2, 0, 7, 8, 9, 0, 1'b1);
    run_session(8'h30, 1'b0);
    checks++;
    if (w_addr.size() !== 2 || w_addr[0] !== 8'h30 || w_addr[1] !== 8'h31 ||
        w_data[1] !== ref_enc(0, 7, 8, 9, 0)) begin
      errors++;
      $display("FAIL invalid_skip: got n=%0d addrs %h %h data1=%h required 2 writes at 30 31",
               w_addr.size(), w_addr[0], w_addr[1], w_data[1]);
    end
    checks++;
    if (err !== 1'b1 || count !== 9'd2 || done !== 1'b1) begin
      errors++;
      $display("FAIL invalid_status: got err=%b count=%0d done=%b required 1 2 1", err, count, done);
    end
    nreq = 1;
    set_req(0, 14, 1, 1, 1, 1, 1'b1);
    run_session(8'h50, 1'b0);
    checks++;
    if (w_addr.size() !== 0 || err !== 1'b1 || done !== 1'b1 || count !== 9'd0) begin
      errors++;
      $display("FAIL invalid_last: got writes=%0d err=%b done=%b count=%0d required 0 1 1 0",
               w_addr.size(), err, done, count);
    end
  endtask

  task automatic test_depth_full;
    nreq = 6;
    for (int i = 0; i < 6; i++) set_req(i, i % 5, i, i + 1, i + 2, 0, 1'b0);
    run_session(8'h80, 1'b0);
    checks++;
    if (w_addr.size() !== 4 || w_addr[0] !== 8'h80 || w_addr[3] !== 8'h83 ||
        w_data[3] !== ref_enc(3, 3, 4, 5, 0)) begin
      errors++;
      $display("FAIL depth_writes: got n=%0d first=%h last=%h data3=%h required 4 80 83",
               w_addr.size(), w_addr[0], w_addr[3], w_data[3]);
    end
    checks++;
    if (full !== 1'b1 || done !== 1'b1 || count !== 9'd4 || rdy_after !== 1'b0 || acc_cyc.size() !== 4) begin
      errors++;
      $display("FAIL depth_status: got full=%b done=%b count=%0d ready_after=%b accepts=%0d required 1 1 4 0 4",
               full, done, count, rdy_after, acc_cyc.size());
    end
  endtask

  task automatic test_reset_mid_and_wrap;
    int n;
    @(negedge clk); start = 1'b1; base_addr = 8'h20;
    @(negedge clk); start = 1'b0;
    req_valid = 1'b1; req_op = 4'd0; req_rs = 5'd1; req_rt = 5'd2; req_rd = 5'd3; req_last = 1'b0;
    n = 0;
    while (im_wen !== 1'b1 && n < 10) begin
      @(negedge clk); n++;
    end
    checks++;
    if (im_wen !== 1'b1) begin
      errors++;
      $display("FAIL midreset_wen: got im_wen=%b required 1 within 10 cycles", im_wen);
    end
    #2 resetn = 1'b0;
    #1;
    checks++;
    if ({req_ready, im_wen, busy, done, full, err} !== 6'b0 || count !== 9'd0 ||
        im_addr !== 8'd0 || im_wdata !== 32'd0) begin
      errors++;
      $display("FAIL midreset_async: got ready=%b wen=%b busy=%b done=%b count=%0d addr=%h data=%h required all 0",
               req_ready, im_wen, busy, done, count, im_addr, im_wdata);
    end
    @(negedge clk); resetn = 1'b1;
    repeat (2) @(negedge clk);
    checks++;
    if (im_wen !== 1'b0 || busy !== 1'b0 || count !== 9'd0) begin
      errors++;
      $display("FAIL midreset_idle: got wen=%b busy=%b count=%0d required 0 0 0", im_wen, busy, count);
    end
    req_valid = 1'b0;
    nreq = 2;
    set_req(0, 0, 1, 2, 3, 0, 1'b0);
    set_req(1, 4, 5, 6, 7, 0, 1'b1);
    run_session(8'hFF, 1'b0);
    checks++;
    if (w_addr.size() !== 2 || w_addr[0] !== 8'hFF || w_addr[1] !== 8'h00) begin
      errors++;
      $display("FAIL wrap: got n=%0d addrs %h %h required ff 00", w_addr.size(), w_addr[0], w_addr[1]);
    end
  endtask

  task automatic test_random;
    logic [7:0] b;
    for (int s = 0; s < 10; s++) begin
      nreq = $urandom_range(1, 6);
      for (int i = 0; i < nreq; i++) begin
        set_req(i, ($urandom_range(0, 3) == 0) ? $urandom_range(12, 15) : $urandom_range(0, 11),
                $urandom_range(0, 31), $urandom_range(0, 31), $urandom_range(0, 31),
                int'($urandom), ($urandom_range(0, 4) == 0));
      end
      r_last[nreq-1] = 1'b1;
      b = 8'($urandom);
      model_session(b);
      run_session(b, 1'b1);
      checks++;
      if (w_addr.size() !== e_addr.size() || acc_cyc.size() !== e_acc) begin
        errors++;
        $display("FAIL rand_counts s%0d: got writes=%0d accepts=%0d required %0d %0d",
                 s, w_addr.size(), acc_cyc.size(), e_addr.size(), e_acc);
      end else begin
        for (int k = 0; k < e_addr.size(); k++) begin
          checks++;
          if (w_addr[k] !== e_addr[k] || w_data[k] !== e_data[k] ||
              w_cyc[k] !== acc_cyc[e_widx[k]] + 1) begin
            errors++;
            $display("FAIL rand_write s%0d w%0d: got %h@%h cyc%0d required %h@%h cyc%0d",
                     s, k, w_data[k], w_addr[k], w_cyc[k], e_data[k], e_addr[k], acc_cyc[e_widx[k]] + 1);
          end
        end
      end
      checks++;
      if (int'(count) !== e_count || err !== e_err || done !== e_done ||
          full !== (e_count == DEPTH) || rdy_after !== 1'b0) begin
        errors++;
        $display("FAIL rand_status s%0d: got count=%0d err=%b done=%b full=%b ready=%b required %0d %b %b %b 0",
                 s, count, err, done, full, rdy_after, e_count, e_err, e_done, (e_count == DEPTH));
      end
    end
  endtask

  initial begin
    test_reset();
    test_single_add();
    test_back_to_back();
    test_j_cmp_bbt();
    test_invalid();
    test_depth_full();
    test_reset_mid_and_wrap();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/cpu_inst_encoder.md
# cpu_inst_encoder

Sequential instruction encoder and instruction-memory loader: the write-side counterpart to the CPU instruction decoder. It accepts one symbolic instruction per valid/ready handshake and encodes it into the exact 32-bit word the decoder recognises. It writes the words to consecutive instruction-memory addresses starting at a programmable base. It sits between the test/boot controller and the instruction RAM write port.

## Interface
Parameters:
- ADDR_W, 8, instruction-memory word-address width
- DEPTH, 256, max words per load session (≤ 2^ADDR_W)

Ports:
- clk  in  1  clock, rising edge
- resetn  in  1  reset, asynchronous, active-low
- start  in  1  pulse; opens a load session (honoured in IDLE/DONE only)
- base_addr  in  ADDR_W  first write address, sampled on start
- req_valid  in  1  request present
- req_ready  out  1  request can be taken this cycle
- req_op  in  4  0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 SW, 6 LW, 7 J, 8 MOV, 9 SLL, 10 CMP, 11 BBT, 12–15 invalid
- req_rs, req_rt, req_rd  in  5 each  register fields
- req_imm  in  26  imm16 = [15:0], shamt = [4:0], J target = [25:0]
- req_last  in  1  final instruction of the session
- im_wen  out  1  instruction-memory write strobe
- im_addr  out  ADDR_W  write address
- im_wdata  out  32  encoded instruction
- busy  out  1  state == LOAD or a write pending
- done  out  1  state == DONE
- full  out  1  count == DEPTH
- err  out  1  sticky: invalid op seen this session
- count  out  ADDR_W+1  words written this session

## Operation
- States: IDLE, LOAD, DONE. Reset → IDLE.
- IDLE/DONE + start → LOAD; ptr ← base_addr; count ← 0; err ← 0. start in LOAD is ignored.
- req_ready = (state == LOAD) && !full. Accept = req_valid && req_ready.
- Encoding (op, rs, rt, rd, low 11 bits):
  - ADD/SUB/AND/OR/XOR: 000000, rs, rt, rd, funct 100000/100010/100100/100101/100110
  - SW/LW: 101011/100011, rs, rt, imm16
  - J: 000010, target26
  - MOV: 000000, rs, rt, rd, 00000001010
  - SLL: 000000, rs forced 0, rt, rd, shamt, 000000
  - CMP: 111110, rs, rt, rd, 11'b0
  - BBT: 111111, rs, rt, imm16
  - Fields not listed for an op are ignored.
- A valid op, once accepted, is registered. Next cycle: im_wen = 1, im_addr = ptr, im_wdata = word. Then ptr += 1 (wraps modulo 2^ADDR_W) and count += 1.
- An invalid op (12–15) is accepted and consumed, but no write occurs. err ← 1, and count and ptr are unchanged.
- An accepted req_last, or an accept that brings count to DEPTH → DONE. The pending write still completes.
- In DONE: req_ready = 0. Outputs hold until the next start.

## Timing
- Reset values: req_ready 0, im_wen 0, im_addr 0, im_wdata 0, busy 0, done 0, full 0, err 0, count 0. Reset clears the pending write immediately (asynchronous).
- Latency: accept at edge N → im_wen high for exactly one cycle after edge N, with count updated at edge N+1.
- Throughput: 1 word/cycle while req_valid is held.
- full and req_ready are registered-state-derived. When the DEPTH-th accept occurs, req_ready drops in the following cycle, so no extra accept is possible.
- The DEPTH-th accept with req_last = 1: single transition to DONE, full = 1.
- An invalid op with req_last = 1 → DONE, no write, err = 1.
- Reset during LOAD: the session is lost and the block returns to IDLE. No write occurs after resetn falls.

## Structure
- Shared package cpu_isa_pkg holds:
  - the op enum (4-bit)
  - opcode constants (6-bit)
  - funct/low-11 constants
  - field bit positions
- The decoder will later reuse cpu_isa_pkg.
- Natural sub-module: cpu_inst_pack, a purely combinational op+fields → 32-bit word. It is instantiated once, ahead of the output register.
- The FSM, pointer and counters live in the top.

## Test plan
- start with base 0x10, then ADD rs=1 rt=2 rd=3, last=1 → one write at 0x10 of 0x00221820; count = 1; done = 1.
- LW rs=4 rt=5 imm=0x0010, then SLL rs=9 rt=6 rd=7 shamt=3, back-to-back → 0x8C850010 @0x10, then 0x000638C0 @0x11 (rs forced to 0).
- J target 0x40, CMP rs=1 rt=2 rd=3, BBT imm 0x1234 (rs = rt = 0) → 0x08000040, 0xF8221800, 0xFC001234.
- op = 13 between two ADDs → only two writes at consecutive addresses; err = 1; count = 2.
- DEPTH = 4, stream 6 requests with valid held → exactly 4 writes; full = 1; done = 1; req_ready low from the cycle after the 4th accept.
- Assert resetn low on the cycle im_wen is high mid-stream → im_wen falls asynchronously and all outputs return to reset values. The next start at base 0xFF wraps ptr to 0x00 after the first write.
